// File: rtl/opl_op_output_pkg.sv
// Shared audio package for the FM operator output stage: waveform
// encodings, datapath widths and the exp-ROM contents generator.
package opl_op_output_pkg;

  localparam int PHASE_W   = 10;
  localparam int ATTEN_W   = 9;
  localparam int LOG_W     = 12;
  localparam int SUM_W     = 13;
  localparam int SAMPLE_W  = 13;
  localparam int EXP_W     = 10;
  localparam int EXP_DEPTH = 256;

  // Fixed-point scale of the exp mantissa: 2^(x/256) is stored as
  // (2^(x/256) - 1) * EXP_MANT, the implicit leading one is re-added later.
  localparam int EXP_MANT = 1024;

  typedef enum logic [2:0] {
    WAVE_SINE   = 3'd0,
    WAVE_HALF   = 3'd1,
    WAVE_ABS    = 3'd2,
    WAVE_QPULSE = 3'd3,
    WAVE_ALT    = 3'd4,
    WAVE_CAMEL  = 3'd5,
    WAVE_SQUARE = 3'd6,
    WAVE_LOGSAW = 3'd7
  } wave_e;

  // One exp-ROM word, evaluated at elaboration only (constant function).
  function automatic logic [EXP_W-1:0] exp_entry(input int idx);
    real v;
    v = (2.0 ** (real'(idx) / real'(EXP_DEPTH)) - 1.0) * real'(EXP_MANT);
    return EXP_W'($rtoi(v + 0.5));
  endfunction

endpackage

// File: rtl/opl_op_output_lut_exp.sv
// 256x10 exp ROM with a 1-cycle registered read; contents are
// round((2^(i/256) - 1) * 1024), generated at elaboration.
module opl_op_output_lut_exp
  import opl_op_output_pkg::*;
(
  input  logic             clk,
  input  logic [7:0]       i_addr,
  output logic [EXP_W-1:0] o_data
);

  logic [EXP_W-1:0] w_rom [EXP_DEPTH];
  logic [EXP_W-1:0] r_data;

  for (genvar g = 0; g < EXP_DEPTH; g++) begin : g_rom
    localparam logic [EXP_W-1:0] ENTRY = exp_entry(g);
    assign w_rom[g] = ENTRY;
  end

  // Registered ROM read.
  // NOTE: the ROM data register has no reset; the pipeline valid bits give
  // it meaning, so a stale word after reset is harmless.
  always_ff @(posedge clk) begin
    r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/opl_op_output.sv
// FM operator output stage: phase -> log-sin ROM address, log-domain
// envelope add, exp ROM + shifter back to linear, sign/mute applied.
// Four-cycle fixed latency, one sample per cycle, no backpressure.
// Optional macro OPL_WAVE_EXT_EN enables the OPL3 waveforms 4-7; without
// it wave[2] is ignored and the log-value bypass mux is absent.
module opl_op_output
  import opl_op_output_pkg::*;
#(
  parameter int OUT_W = SAMPLE_W  // only 13 is supported
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [PHASE_W-1:0]      phase,
  input  logic [ATTEN_W-1:0]      atten,
  input  logic [2:0]              wave,
  output logic [7:0]              lut_idx,
  input  logic [LOG_W-1:0]        lut_value,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample
);

  // ---------------- S1 decode ----------------
  wave_e      w_wave;
  logic [8:0] w_eff;
  logic [7:0] w_idx;
  logic       w_sign;
  logic       w_mute;
`ifdef OPL_WAVE_EXT_EN
  logic             w_byp;
  logic [LOG_W-1:0] w_byp_log;
  assign w_wave = wave_e'(wave);
`else
  logic w_unused_wave;
  assign w_wave        = wave_e'({1'b0, wave[1:0]});
  assign w_unused_wave = wave[2];
`endif

  // Waveform decode: effective phase, sign and mute for this sample.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_eff  = phase[8:0];
    w_sign = phase[9];
    w_mute = 1'b0;
`ifdef OPL_WAVE_EXT_EN
    w_byp     = 1'b0;
    w_byp_log = '0;
`endif
    case (w_wave)
      WAVE_HALF:   begin w_mute = phase[9]; w_sign = 1'b0; end
      WAVE_ABS:    w_sign = 1'b0;
      WAVE_QPULSE: begin w_mute = phase[8]; w_sign = 1'b0; end
`ifdef OPL_WAVE_EXT_EN
      WAVE_ALT:    begin w_mute = phase[9]; w_eff = {phase[7:0], 1'b0}; w_sign = phase[8]; end
      WAVE_CAMEL:  begin w_mute = phase[9]; w_eff = {phase[7:0], 1'b0}; w_sign = 1'b0; end
      WAVE_SQUARE: w_byp = 1'b1;
      WAVE_LOGSAW: begin
        w_byp     = 1'b1;
        w_byp_log = {(phase[9] ? ~phase[8:0] : phase[8:0]), 3'b000};
      end
`endif
      default: ;
    endcase
    w_idx = w_eff[8] ? ~w_eff[7:0] : w_eff[7:0];
  end

  // ---------------- pipeline registers ----------------
  logic               r_s1_valid, r_s1_sign, r_s1_mute;
  logic [ATTEN_W-1:0] r_s1_atten;
  logic [7:0]         r_lut_idx;
  logic               r_s2_valid, r_s2_sign, r_s2_mute;
  logic [ATTEN_W-1:0] r_s2_atten;
  logic               r_s3_valid, r_s3_sign, r_s3_mute;
  logic [4:0]         r_s3_shift;
  logic               r_out_valid;
  logic signed [OUT_W-1:0] r_out_sample;
`ifdef OPL_WAVE_EXT_EN
  logic             r_s1_byp, r_s2_byp;
  logic [LOG_W-1:0] r_s1_byp_log, r_s2_byp_log;
`endif

  // S1: register the ROM address and per-sample control; S2: align the
  // control with the log-sin ROM data that arrives one cycle later.
  // NOTE: sequential state uses <= so each stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0; r_s1_sign <= 1'b0; r_s1_mute <= 1'b0;
      r_s1_atten <= '0;   r_lut_idx <= '0;
      r_s2_valid <= 1'b0; r_s2_sign <= 1'b0; r_s2_mute <= 1'b0;
      r_s2_atten <= '0;
`ifdef OPL_WAVE_EXT_EN
      r_s1_byp <= 1'b0; r_s1_byp_log <= '0;
      r_s2_byp <= 1'b0; r_s2_byp_log <= '0;
`endif
    end else begin
      r_s1_valid <= in_valid; r_s1_sign <= w_sign; r_s1_mute <= w_mute;
      r_s1_atten <= atten;    r_lut_idx <= w_idx;
      r_s2_valid <= r_s1_valid; r_s2_sign <= r_s1_sign; r_s2_mute <= r_s1_mute;
      r_s2_atten <= r_s1_atten;
`ifdef OPL_WAVE_EXT_EN
      r_s1_byp <= w_byp;    r_s1_byp_log <= w_byp_log;
      r_s2_byp <= r_s1_byp; r_s2_byp_log <= r_s1_byp_log;
`endif
    end
  end

  assign lut_idx = r_lut_idx;

  // ---------------- S2 log-domain add ----------------
  logic [LOG_W-1:0] w_log;
  logic [SUM_W-1:0] w_sum;
`ifdef OPL_WAVE_EXT_EN
  assign w_log = r_s2_byp ? r_s2_byp_log : lut_value;
`else
  assign w_log = lut_value;
`endif
  // Max 2137 + 4088 = 6225 fits in 13 bits, so no saturation is needed.
  assign w_sum = SUM_W'(w_log) + SUM_W'({r_s2_atten, 3'b000});

  // ---------------- S3 exp lookup ----------------
  logic [EXP_W-1:0] w_exp;

  opl_op_output_lut_exp u_lut_exp (
    .clk    (clk),
    .i_addr (~w_sum[7:0]),
    .o_data (w_exp)
  );

  // S3: carry the integer shift and control alongside the exp ROM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s3_valid <= 1'b0; r_s3_sign <= 1'b0; r_s3_mute <= 1'b0;
      r_s3_shift <= '0;
    end else begin
      r_s3_valid <= r_s2_valid; r_s3_sign <= r_s2_sign; r_s3_mute <= r_s2_mute;
      r_s3_shift <= w_sum[12:8];
    end
  end

  // ---------------- S4 shift and sign ----------------
  logic [11:0]             w_mant;
  logic [11:0]             w_mag;
  logic signed [OUT_W-1:0] w_mag_s;
  assign w_mant  = {1'b1, w_exp, 1'b0};
  assign w_mag   = (r_s3_shift >= 5'd12) ? 12'd0 : (w_mant >> r_s3_shift);
  assign w_mag_s = signed'(OUT_W'(w_mag));

  // S4: apply mute and sign, register the output sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else begin
      r_out_valid <= r_s3_valid;
      if (r_s3_mute)      r_out_sample <= '0;
      else if (r_s3_sign) r_out_sample <= -w_mag_s;
      else                r_out_sample <= w_mag_s;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

endmodule

// File: tb/tb_opl_op_output.sv
// Self-checking bench for opl_op_output: directed cases with constant
// expectations, then randomized traffic scored against a real-arithmetic
// reference model. Honors OPL_WAVE_EXT_EN the same way as the design.
module tb_opl_op_output;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [9:0]        phase = '0;
  logic [8:0]        atten = '0;
  logic [2:0]        wave = '0;
  logic [7:0]        lut_idx;
  logic [11:0]       lut_value = '0;
  logic              out_valid;
  logic signed [12:0] out_sample;

  int n_checks = 0;
  int n_fail   = 0;

  int logsin_tab [256];
  int exp_tab    [256];
  bit vpipe [$];   // expected out_valid, one entry per cycle
  int sq    [$];   // expected samples in order

  typedef struct {
    logic [2:0] wv;
    logic [9:0] ph;
    logic [8:0] at;
    int         idx;
    int         smp;
  } dir_t;
  dir_t dirs [$];

  opl_op_output dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .phase      (phase),
    .atten      (atten),
    .wave       (wave),
    .lut_idx    (lut_idx),
    .lut_value  (lut_value),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  // External log-sin quarter-wave ROM: registered read of lut_idx.
  always @(posedge clk) lut_value <= 12'(logsin_tab[lut_idx]);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model straight from the waveform rules and the ROM formulas.
  function automatic void model(input logic [2:0] wv, input logic [9:0] ph,
                                input logic [8:0] at, output int idx, output int smp);
    int w, eff, logv, sum, shift, mag;
    bit sgn, mute, byp;
`ifdef OPL_WAVE_EXT_EN
    w = int'(wv);
`else
    w = int'(wv) % 4;
`endif
    eff = int'(ph); sgn = ph[9]; mute = 0; byp = 0; logv = 0;
    case (w)
      1: begin mute = ph[9]; sgn = 0; end
      2: sgn = 0;
      3: begin mute = ph[8]; sgn = 0; end
      4: begin mute = ph[9]; eff = (int'(ph) * 2) % 1024; sgn = eff >= 512; end
      5: begin mute = ph[9]; eff = (int'(ph) * 2) % 1024; sgn = 0; end
      6: byp = 1;
      7: begin
        byp  = 1;
        logv = (ph[9] ? 511 - int'(ph[8:0]) : int'(ph[8:0])) * 8;
      end
      default: ;
    endcase
    idx = ((eff / 256) % 2 == 1) ? 255 - (eff % 256) : eff % 256;
    if (!byp) logv = logsin_tab[idx];
    sum   = logv + int'(at) * 8;
    shift = sum / 256;
    mag   = (shift >= 12) ? 0 : (2048 + 2 * exp_tab[255 - sum % 256]) / (1 << shift);
    smp   = mute ? 0 : (sgn ? -mag : mag);
  endfunction

  // Drive one cycle of input, then check the outputs at the falling edge.
  task automatic tick(input bit v, input logic [2:0] wv, input logic [9:0] ph,
                      input logic [8:0] at, input int e_idx, input int e_smp);
    bit ev;
    in_valid = v; wave = wv; phase = ph; atten = at;
    vpipe.push_back(v);
    if (v) sq.push_back(e_smp);
    @(negedge clk);
    if (v) check("lut_idx", int'(lut_idx), e_idx);
    ev = vpipe.pop_front();
    check("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      if (sq.size() == 0) check("sample_order", 0, 1);
      else                check("out_sample", int'(out_sample), sq.pop_front());
    end
  endtask

  task automatic rtick(input bit v);
    logic [2:0] wv;
    logic [9:0] ph;
    logic [8:0] at;
    int idx, smp;
    wv = 3'($urandom);
    ph = 10'($urandom);
    at = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 40));
    model(wv, ph, at, idx, smp);
    tick(v, wv, ph, at, idx, smp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 10'd0, 9'd0, 0, 0);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_lut_idx", int'(lut_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    vpipe = {1'b0, 1'b0, 1'b0};
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      real s;
      s = $sin((real'(i) + 0.5) * 3.14159265358979 / 512.0);
      logsin_tab[i] = $rtoi(-$ln(s) / $ln(2.0) * 256.0 + 0.5);
      exp_tab[i]    = $rtoi(($exp($ln(2.0) * real'(i) / 256.0) - 1.0) * 1024.0 + 0.5);
    end

    dirs.push_back('{3'd0, 10'h100, 9'h000, 8'hFF, 4084});
    dirs.push_back('{3'd0, 10'h300, 9'h100, 8'hFF, -15});
    dirs.push_back('{3'd1, 10'h300, 9'h000, 8'hFF, 0});
    dirs.push_back('{3'd3, 10'h140, 9'h000, 8'hBF, 0});
    dirs.push_back('{3'd2, 10'h300, 9'h000, 8'hFF, 4084});
    dirs.push_back('{3'd0, 10'h155, 9'h1FF, 8'hAA, 0});
`ifdef OPL_WAVE_EXT_EN
    dirs.push_back('{3'd6, 10'h200, 9'h000, 8'h00, -4084});
    dirs.push_back('{3'd4, 10'h080, 9'h000, 8'hFF, 4084});
`else
    dirs.push_back('{3'd6, 10'h200, 9'h000, 8'h00, 12});
    dirs.push_back('{3'd4, 10'h080, 9'h000, 8'h80, 2896});
`endif

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check("por_out_valid", int'(out_valid), 0);
    check("por_out_sample", int'(out_sample), 0);
    check("por_lut_idx", int'(lut_idx), 0);
    reset = 1'b0;
    vpipe = {1'b0, 1'b0, 1'b0};

    // Directed cases, back to back.
    foreach (dirs[i]) tick(1'b1, dirs[i].wv, dirs[i].ph, dirs[i].at, dirs[i].idx, dirs[i].smp);
    idle(4);

    // 8 back-to-back, 3-cycle gap, 2 more.
    for (int i = 0; i < 8; i++) rtick(1'b1);
    for (int i = 0; i < 3; i++) rtick(1'b0);
    for (int i = 0; i < 2; i++) rtick(1'b1);
    idle(4);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 400; i++) rtick($urandom_range(0, 9) < 7);
    idle(4);

    // Reset with samples in flight: they must never emerge.
    for (int i = 0; i < 3; i++) rtick(1'b1);
    do_reset();
    idle(5);
    for (int i = 0; i < 6; i++) rtick(1'b1);
    idle(4);

    check("drain", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
